aer_receiver: RTL and testbench

- Consumes the polarity-corrected 9-bit AER word from the DAVIS240C pad-level bus conditioning stage.
- Runs the 4-phase REQ/ACK handshake with the sensor and decodes row/column address words.
- Pairs each column word with the most recent row word and buffers the resulting events in a small FIFO for the downstream event-processing logic.

---
 rtl/aer_receiver.sv | 152 +++++++++++++++
 tb/tb_aer_receiver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/aer_receiver.sv
// DAVIS240C AER receiver: 4-phase REQ/ACK, row/column pairing into a FWFT event FIFO.
// REQ fall to ACK low takes SETTLE_CYCLES+4 clk cycles; a full FIFO withholds ACK from the sensor.
module aer_receiver #(
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [8:0]  aer_data,
   input  logic        aer_req_n,
   output logic        aer_ack_n,
   output logic        ev_valid,
   input  logic        ev_ready,
   output logic [7:0]  ev_row,
   output logic [7:0]  ev_col,
   output logic [15:0] orphan_cnt,
   output logic        timeout_err
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_ACK,
      S_RELEASE
   } state_t;

   state_t        state;
   logic          req_meta;
   logic          req_s;
   logic [3:0]    settle_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [7:0]    row_reg;
   logic          row_seen;

   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          push;
   logic          pop;
   logic          is_col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_meta <= 1'b1;
         req_s    <= 1'b1;
      end else begin
         req_meta <= aer_req_n;
         req_s    <= req_meta;
      end
   end

   // aer_data is only looked at in CAPTURE, after the settle window has let the bus stabilise
   assign is_col   = aer_data[8];
   assign ev_valid = (count != '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign pop      = ev_valid && ev_ready;
   assign push     = (state == S_CAPTURE) && is_col && row_seen && (!full || pop);
   assign ev_row   = mem[rd_ptr][15:8];
   assign ev_col   = mem[rd_ptr][7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         settle_cnt  <= '0;
         tmo_cnt     <= '0;
         aer_ack_n   <= 1'b1;
         row_reg     <= '0;
         row_seen    <= 1'b0;
         orphan_cnt  <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               aer_ack_n <= 1'b1;
               if (!req_s) begin
                  settle_cnt <= 4'(SETTLE_CYCLES - 1);
                  state      <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (settle_cnt == '0) state <= S_CAPTURE;
               else                  settle_cnt <= settle_cnt - 4'd1;
            end
            S_CAPTURE: begin
               if (!is_col) begin
                  row_reg   <= aer_data[7:0];
                  row_seen  <= 1'b1;
                  aer_ack_n <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= S_ACK;
               end else if (!row_seen) begin
                  if (orphan_cnt != 16'hFFFF) orphan_cnt <= orphan_cnt + 16'd1;
                  aer_ack_n <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= S_ACK;
               end else if (push) begin
                  aer_ack_n <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= S_ACK;
               end
            end
            S_ACK: begin
               if (req_s) begin
                  aer_ack_n <= 1'b1;
                  state     <= S_RELEASE;
               end else begin
                  // ACK is never forced high; the error just flags a stuck sensor
                  if (tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + 1'b1;
                  if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
               end
            end
            S_RELEASE: begin
               aer_ack_n <= 1'b1;
               state     <= S_IDLE;
            end
            default: begin
               aer_ack_n <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {row_reg, aer_data[7:0]};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_aer_receiver.sv
// Directed bench for aer_receiver: sensor-side handshake model plus hand-computed expectations.
module tb_aer_receiver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [8:0]  aer_data;
   logic        aer_req_n;
   logic        aer_ack_n;
   logic        ev_valid;
   logic        ev_ready;
   logic [7:0]  ev_row;
   logic [7:0]  ev_col;
   logic [15:0] orphan_cnt;
   logic        timeout_err;

   int n_cmp = 0;
   int n_bad = 0;

   aer_receiver #(
      .SETTLE_CYCLES (2),
      .TIMEOUT_CYCLES(1024),
      .FIFO_DEPTH    (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .aer_data   (aer_data),
      .aer_req_n  (aer_req_n),
      .aer_ack_n  (aer_ack_n),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_row     (ev_row),
      .ev_col     (ev_col),
      .orphan_cnt (orphan_cnt),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic [8:0] w);
      @(negedge clk);
      aer_data  = w;
      aer_req_n = 1'b0;
   endtask

   // counts negedges from now until ACK is seen low
   task automatic wait_ack_lo(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (aer_ack_n !== 1'b0 && n < 50);
      check({tag, " ack latency"}, n, 6);
   endtask

   task automatic release_req(input string tag);
      int n = 0;
      @(negedge clk);
      aer_req_n = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (aer_ack_n !== 1'b1 && n < 50);
      check({tag, " release latency"}, n, 3);
   endtask

   task automatic send(input logic [8:0] w, input string tag);
      drive_req(w);
      wait_ack_lo(tag);
      release_req(tag);
   endtask

   task automatic pop_one();
      @(negedge clk);
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      aer_data  = 9'h000;
      aer_req_n = 1'b1;
      ev_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst ack_n", aer_ack_n, 1);
      check("rst ev_valid", ev_valid, 0);
      check("rst ev_row", ev_row, 0);
      check("rst ev_col", ev_col, 0);
      check("rst orphan", orphan_cnt, 0);
      check("rst timeout", timeout_err, 0);
      rst_n = 1'b1;

      // column before any row: counted as orphan, no event
      send(9'h107, "orphan");
      check("orphan cnt", orphan_cnt, 1);
      check("orphan no event", ev_valid, 0);

      send(9'h02A, "row2a");
      send(9'h115, "col15");
      check("ev1 valid", ev_valid, 1);
      check("ev1 row", ev_row, 8'h2A);
      check("ev1 col", ev_col, 8'h15);
      check("ev1 orphan held", orphan_cnt, 1);
      pop_one();
      check("ev1 drained", ev_valid, 0);

      // consecutive rows overwrite the row register
      send(9'h010, "row10");
      send(9'h011, "row11");
      send(9'h120, "col20");
      check("ev2 row", ev_row, 8'h11);
      check("ev2 col", ev_col, 8'h20);
      pop_one();
      check("ev2 single", ev_valid, 0);

      // fill the FIFO, then stall the ninth handshake
      send(9'h001, "row01");
      for (int i = 0; i < 8; i++) send({1'b1, 8'(i)}, "fill");
      check("full head valid", ev_valid, 1);
      check("full head col", ev_col, 8'h00);
      drive_req(9'h108);
      repeat (20) @(negedge clk);
      check("stall ack_n", aer_ack_n, 1);
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
      check("unstall ack_n", aer_ack_n, 0);
      release_req("unstall");
      for (int i = 1; i < 9; i++) begin
         check("drain valid", ev_valid, 1);
         check("drain col", ev_col, 32'(i));
         check("drain row", ev_row, 8'h01);
         pop_one();
      end
      check("drain empty", ev_valid, 0);

      // REQ held low after ACK: sticky timeout after 1024 ACK cycles
      drive_req(9'h033);
      wait_ack_lo("tmo");
      repeat (1000) @(negedge clk);
      check("tmo early", timeout_err, 0);
      check("tmo ack held", aer_ack_n, 0);
      repeat (100) @(negedge clk);
      check("tmo set", timeout_err, 1);
      check("tmo ack still low", aer_ack_n, 0);
      release_req("tmo");
      check("tmo sticky", timeout_err, 1);

      // reset in ACK with REQ held low: word is recaptured as an orphan
      drive_req(9'h144);
      wait_ack_lo("rstack");
      check("rstack event", ev_valid, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstack ack_n", aer_ack_n, 1);
      check("rstack ev_valid", ev_valid, 0);
      check("rstack orphan", orphan_cnt, 0);
      check("rstack timeout", timeout_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ack_lo("recap");
      check("recap orphan", orphan_cnt, 1);
      check("recap no event", ev_valid, 0);
      release_req("recap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
